// File: rtl/reg_file_sb.sv
// Integer register file with write-through read bypass, optional hardwired x0 and a
// per-register pending-write scoreboard that drives operand hazard flags and a busy count.
module reg_file_sb #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic [AW:0]     busy_cnt
);

  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] pending_q, pending_d;
  logic [AW:0]      busy_cnt_q, busy_cnt_d;
  logic             wr_ok, iss_ok;
  logic             rs1_pend, rs2_pend;

  // Addresses beyond NREGS and, when hardwired, register 0 are never stored or tracked.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_ok  = we && addr_ok(wr_addr);
  assign iss_ok = iss_valid && addr_ok(iss_rd);

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    rs1_pend = 1'b0;
    rs2_pend = 1'b0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (rs1_addr == AW'(i)) begin
        rs1_data = regs_q[i];
        rs1_pend = pending_q[i];
      end
      if (rs2_addr == AW'(i)) begin
        rs2_data = regs_q[i];
        rs2_pend = pending_q[i];
      end
    end
    // The completing write is forwarded, so it no longer counts as a hazard.
    if (!addr_ok(rs1_addr)) begin
      rs1_data = '0;
      rs1_pend = 1'b0;
    end else if (wr_ok && (wr_addr == rs1_addr)) begin
      rs1_data = wr_data;
      rs1_pend = 1'b0;
    end
    if (!addr_ok(rs2_addr)) begin
      rs2_data = '0;
      rs2_pend = 1'b0;
    end else if (wr_ok && (wr_addr == rs2_addr)) begin
      rs2_data = wr_data;
      rs2_pend = 1'b0;
    end
    rs1_busy = rs1_pend;
    rs2_busy = rs2_pend;
  end

  // Set beats clear on the same index: a fresh producer keeps the register pending.
  always_comb begin
    pending_d  = pending_q;
    busy_cnt_d = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      pending_d[i] = (iss_ok && (iss_rd == AW'(i))) ||
                     (pending_q[i] && !(wr_ok && (wr_addr == AW'(i))));
      busy_cnt_d   = busy_cnt_d + CW'(pending_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      pending_q  <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (wr_ok && (wr_addr == AW'(i))) regs_q[i] <= wr_data;
      end
      pending_q  <= pending_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: expectations are queued as stimulus is applied and
// drained against the DUT outputs once they have settled.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, iss_rd;
  logic [63:0] rs1_data, rs2_data, wr_data;
  logic        rs1_busy, rs2_busy, we, iss_valid;
  logic [5:0]  busy_cnt;

  logic [4:0]  s_rs1_addr, s_rs2_addr, s_wr_addr, s_iss_rd;
  logic [63:0] s_rs1_data, s_rs2_data, s_wr_data;
  logic        s_rs1_busy, s_rs2_busy, s_we, s_iss_valid;
  logic [5:0]  s_busy_cnt;

  always #5 clk = ~clk;

  reg_file_sb #(.XLEN(64), .NREGS(32), .AW(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .busy_cnt(busy_cnt)
  );

  reg_file_sb #(.XLEN(64), .NREGS(16), .AW(5), .ZERO_REG(1)) dut_small (
    .clk(clk), .rst_n(rst_n), .rs1_addr(s_rs1_addr), .rs2_addr(s_rs2_addr),
    .rs1_data(s_rs1_data), .rs2_data(s_rs2_data), .rs1_busy(s_rs1_busy),
    .rs2_busy(s_rs2_busy), .we(s_we), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .iss_valid(s_iss_valid), .iss_rd(s_iss_rd), .busy_cnt(s_busy_cnt)
  );

  localparam int SigRs1Data = 0, SigRs2Data = 1, SigRs1Busy = 2, SigRs2Busy = 3;
  localparam int SigCnt = 4, SigSRs1Data = 5, SigSRs1Busy = 6, SigSRs2Busy = 7, SigSCnt = 8;

  typedef struct {
    string       tag;
    int          sig;
    logic [63:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [63:0] sample(input int sig);
    case (sig)
      SigRs1Data:  return rs1_data;
      SigRs2Data:  return rs2_data;
      SigRs1Busy:  return 64'(rs1_busy);
      SigRs2Busy:  return 64'(rs2_busy);
      SigCnt:      return 64'(busy_cnt);
      SigSRs1Data: return s_rs1_data;
      SigSRs1Busy: return 64'(s_rs1_busy);
      SigSRs2Busy: return 64'(s_rs2_busy);
      default:     return 64'(s_busy_cnt);
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sig, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    exp_q.push_back(e);
  endtask

  // Let combinational outputs settle, then compare everything queued.
  task automatic drain();
    exp_t        e;
    logic [63:0] obs;
    #1;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = sample(e.sig);
      n_checks++;
      assert (obs === e.exp) begin
        n_pass++;
      end else begin
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; iss_valid = 1'b0; s_we = 1'b0; s_iss_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; idle();
    rs1_addr = '0; rs2_addr = '0; wr_addr = '0; iss_rd = '0; wr_data = '0;
    s_rs1_addr = '0; s_rs2_addr = '0; s_wr_addr = '0; s_iss_rd = '0; s_wr_data = '0;
    tick(); tick();
    rst_n = 1'b1;

    // Reset clears storage; a write in the reset cycle is lost
    we = 1'b1; wr_addr = 5'd3; wr_data = 64'd1470; iss_valid = 1'b1; iss_rd = 5'd3;
    tick(); idle();
    rs1_addr = 5'd3;
    expect_val("x3_written", SigRs1Data, 64'd1470);
    expect_val("x3_pending", SigRs1Busy, 64'd1);
    drain();
    rst_n = 1'b0; we = 1'b1; wr_addr = 5'd3; wr_data = 64'd99;
    tick(); idle(); rst_n = 1'b1;
    expect_val("rst_x3_data", SigRs1Data, 64'd0);
    expect_val("rst_x3_busy", SigRs1Busy, 64'd0);
    expect_val("rst_cnt", SigCnt, 64'd0);
    drain();

    // Write with same-cycle bypass, then from storage
    we = 1'b1; wr_addr = 5'd1; wr_data = 64'd6000; rs1_addr = 5'd1;
    expect_val("x1_bypass", SigRs1Data, 64'd6000);
    drain();
    tick(); idle();
    expect_val("x1_stored", SigRs1Data, 64'd6000);
    drain();

    // x0 is never written and never busy
    we = 1'b1; wr_addr = 5'd0; wr_data = 64'd5; iss_valid = 1'b1; iss_rd = 5'd0;
    rs1_addr = 5'd0;
    expect_val("x0_no_bypass", SigRs1Data, 64'd0);
    drain();
    tick(); idle();
    expect_val("x0_data", SigRs1Data, 64'd0);
    expect_val("x0_busy", SigRs1Busy, 64'd0);
    expect_val("x0_cnt", SigCnt, 64'd0);
    drain();

    // Issue x5, then write back with bypass hiding the hazard
    iss_valid = 1'b1; iss_rd = 5'd5;
    tick(); idle(); rs2_addr = 5'd5;
    expect_val("x5_busy", SigRs2Busy, 64'd1);
    expect_val("x5_cnt", SigCnt, 64'd1);
    drain();
    we = 1'b1; wr_addr = 5'd5; wr_data = 64'hAA;
    expect_val("x5_wb_busy", SigRs2Busy, 64'd0);
    expect_val("x5_wb_data", SigRs2Data, 64'hAA);
    drain();
    tick(); idle();
    expect_val("x5_done_cnt", SigCnt, 64'd0);
    expect_val("x5_done_busy", SigRs2Busy, 64'd0);
    expect_val("x5_done_data", SigRs2Data, 64'hAA);
    drain();

    // Set wins over clear on the same register
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick(); idle(); rs1_addr = 5'd7;
    expect_val("x7_cnt", SigCnt, 64'd1);
    drain();
    iss_valid = 1'b1; iss_rd = 5'd7; we = 1'b1; wr_addr = 5'd7; wr_data = 64'h77;
    expect_val("coll_bypass_busy", SigRs1Busy, 64'd0);
    expect_val("coll_bypass_data", SigRs1Data, 64'h77);
    drain();
    tick(); idle();
    expect_val("coll_busy", SigRs1Busy, 64'd1);
    expect_val("coll_data", SigRs1Data, 64'h77);
    expect_val("coll_cnt", SigCnt, 64'd1);
    drain();

    // Set and clear on different registers net to zero
    iss_valid = 1'b1; iss_rd = 5'd8; we = 1'b1; wr_addr = 5'd7; wr_data = 64'h78;
    tick(); idle(); rs2_addr = 5'd8;
    expect_val("swap_cnt", SigCnt, 64'd1);
    expect_val("swap_x7_busy", SigRs1Busy, 64'd0);
    expect_val("swap_x8_busy", SigRs2Busy, 64'd1);
    drain();

    // Re-issue pending x8 and write back non-pending x10: count unchanged
    iss_valid = 1'b1; iss_rd = 5'd8; we = 1'b1; wr_addr = 5'd10; wr_data = 64'h10;
    tick(); idle(); rs1_addr = 5'd10;
    expect_val("reiss_cnt", SigCnt, 64'd1);
    expect_val("x10_data", SigRs1Data, 64'h10);
    expect_val("x10_busy", SigRs1Busy, 64'd0);
    drain();
    we = 1'b1; wr_addr = 5'd8; wr_data = 64'h88;
    tick(); idle();
    expect_val("x8_clear_cnt", SigCnt, 64'd0);
    drain();

    // Both ports on one register during its writeback
    iss_valid = 1'b1; iss_rd = 5'd4;
    tick(); idle();
    rs1_addr = 5'd4; rs2_addr = 5'd4;
    we = 1'b1; wr_addr = 5'd4; wr_data = 64'h1234;
    expect_val("dual_rs1_data", SigRs1Data, 64'h1234);
    expect_val("dual_rs2_data", SigRs2Data, 64'h1234);
    expect_val("dual_rs1_busy", SigRs1Busy, 64'd0);
    expect_val("dual_rs2_busy", SigRs2Busy, 64'd0);
    drain();
    tick(); idle();
    expect_val("dual_cnt", SigCnt, 64'd0);
    drain();

    // NREGS=16 instance: issue every address, count saturates at 15
    for (int i = 0; i < 32; i++) begin
      s_iss_valid = 1'b1; s_iss_rd = 5'(i);
      tick();
    end
    idle();
    s_rs1_addr = 5'd15; s_rs2_addr = 5'd0;
    expect_val("sat_cnt", SigSCnt, 64'd15);
    expect_val("sat_x15_busy", SigSRs1Busy, 64'd1);
    expect_val("sat_x0_busy", SigSRs2Busy, 64'd0);
    drain();
    for (int a = 16; a < 32; a++) begin
      s_we = 1'b1; s_wr_addr = 5'(a); s_wr_data = 64'hBEEF;
      s_rs1_addr = 5'(a); s_rs2_addr = 5'(a);
      expect_val($sformatf("oor_data_%0d", a), SigSRs1Data, 64'd0);
      expect_val($sformatf("oor_busy_%0d", a), SigSRs2Busy, 64'd0);
      drain();
      tick();
    end
    idle();
    expect_val("oor_cnt", SigSCnt, 64'd15);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
